fixed_priority_arbiter: RTL and testbench
=========================================

Name: fixed_priority_arbiter

Overview:
- Four-requester (width-parameterised) fixed-priority arbiter with registered one-hot grant output.
- Each cycle it samples the request vector and grants exactly one requester: the highest-priority active one.
- Sits between multiple bus masters/clients and a single shared resource; requesters hold REQ until served.

Parameters:
- N, 4, number of requesters; width of REQ and GNT (N >= 2).
- MSB_HIGH, 1, priority order: 1 = REQ[N-1] highest and REQ[0] lowest; 0 = REQ[0] highest.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low; asserting it clears state immediately, deassertion is sampled synchronously.
- REQ  input  N  request vector, one bit per requester, active-high, level-sensitive.
- GNT  output  N  grant vector, one-hot or all-zero, driven directly from a register.

Behaviour:
- Reset:
  - While rst_n = 0, GNT = 0 immediately, without waiting for a clock edge, and held.
  - The first grant can appear on the first rising clk edge after rst_n goes high.
- Arbitration, default MSB_HIGH = 1, evaluated combinationally on REQ:
  - REQ[3] set -> next grant 4'b1000.
  - Else REQ[2] set -> 4'b0100.
  - Else REQ[1] set -> 4'b0010.
  - Else REQ[0] set -> 4'b0001.
  - Else 4'b0000.
  - MSB_HIGH = 0 reverses the order (REQ[0] highest).
- Latency:
  - The next grant is registered into GNT on each rising clk edge.
  - GNT reflects the REQ sampled at the previous rising edge: exactly one cycle of latency.
  - No combinational path from REQ to GNT.
- No memory of past grants; no round-robin and no grant locking:
  - A higher-priority request arriving preempts the current grant on the next edge.
  - A lower-priority requester may starve; this is by design.
- Invariants:
  - GNT is always one-hot or zero; never more than one bit set.
  - GNT != 0 only if the corresponding REQ bit was set at the previous sampling edge.
- Idle: REQ = 0 -> GNT = 0 after the next edge.
- Reset mid-operation: asserting rst_n forces GNT = 0 asynchronously, regardless of REQ or pending grants. After release, arbitration resumes from a clean state on the next edge.
- REQ X/Z values are not supported; REQ must be driven to a known value whenever rst_n = 1.
- Implementation structure:
  - A priority encoder, generated for arbitrary N.
  - A grant register with async clear.
  - An optional internal state register, one state per grant plus IDLE, encoding the current grant. State transitions are purely a function of REQ, as listed above.

Test Plan:
- Reset: rst_n = 0 with REQ = 4'b1111 -> GNT = 4'b0000 immediately and on every edge while in reset. Release -> the first edge gives GNT = 4'b1000.
- Single requests, REQ changed on the falling edge: 4'b1000 -> 4'b1000; 4'b0010 -> 4'b0010; 4'b0100 -> 4'b0100; 4'b0001 -> 4'b0001. Each appears at the next rising edge, not before.
- Contention sequence, one value per cycle: 4'b1010 -> 4'b1000; 4'b0110 -> 4'b0100; 4'b1110 -> 4'b1000; 4'b1111 -> 4'b1000; 4'b0011 -> 4'b0010.
- Preemption and idle: REQ 4'b0001 then 4'b0101 -> GNT 4'b0001 then 4'b0100. REQ 4'b0000 -> GNT 4'b0000 on the next edge.
- Mid-run reset: with REQ = 4'b0010 and GNT = 4'b0010, drop rst_n between edges -> GNT = 0 at once. Hold reset 10 cycles -> GNT stays 0. Release -> GNT = 4'b0010 on the next edge.
- Randomised run of 1000 cycles with a reference model:
  - Check GNT is one-hot or zero on every cycle.
  - Check GNT equals the priority encode of the previous-cycle REQ.
  - Repeat with MSB_HIGH = 0 and N = 8.

Source files
------------

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority arbiter with a registered one-hot grant.
// The highest-priority active request wins on every clock edge.
module fixed_priority_arbiter #(
   parameter int N        = 4,
   parameter bit MSB_HIGH = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] REQ,
   output logic [N-1:0] GNT
);

   logic [N-1:0] next_gnt;

   if (MSB_HIGH) begin : g_msb_high
      // Scan upward so the highest set request overwrites any lower one.
      always_comb begin
         next_gnt = '0;
         for (int i = 0; i < N; i++) begin
            if (REQ[i]) begin
               next_gnt    = '0;
               next_gnt[i] = 1'b1;
            end
         end
      end
   end else begin : g_lsb_high
      // Scan downward so the lowest set request overwrites any higher one.
      always_comb begin
         next_gnt = '0;
         for (int i = N - 1; i >= 0; i--) begin
            if (REQ[i]) begin
               next_gnt    = '0;
               next_gnt[i] = 1'b1;
            end
         end
      end
   end

   // Grant register: cleared asynchronously, reloaded every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         GNT <= '0;
      end else begin
         GNT <= next_gnt;
      end
   end

endmodule

// File: tb/tb_fixed_priority_arbiter.sv
// Bench for fixed_priority_arbiter: directed literals plus a random
// run, for N=4/MSB_HIGH=1 and N=8/MSB_HIGH=0.
module tb_fixed_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req4;
   logic [3:0] gnt4;
   logic [7:0] req8;
   logic [7:0] gnt8;

   int n_checks = 0;
   int n_fails  = 0;

   logic [3:0] exp4;
   logic [7:0] exp8;
   logic [3:0] last_e;

   always #5 clk = ~clk;

   fixed_priority_arbiter #(.N(4), .MSB_HIGH(1'b1)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .REQ   (req4),
      .GNT   (gnt4)
   );

   fixed_priority_arbiter #(.N(8), .MSB_HIGH(1'b0)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .REQ   (req8),
      .GNT   (gnt8)
   );

   // Reference: highest set bit as a power of two, or lowest set bit.
   function automatic logic [7:0] model(input logic [7:0] r,
                                        input int n, input bit msb);
      int v;
      int p;
      v = int'(r) & ((1 << n) - 1);
      if (v == 0) return 8'd0;
      if (msb) begin
         p = 1;
         while (p * 2 <= v) p = p * 2;
         return 8'(p);
      end
      return 8'(v & -v);
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Expected grant tracks the request seen at each sampling edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp4 = '0;
         exp8 = '0;
      end else begin
         exp4 = 4'(model({4'd0, req4}, 4, 1'b1));
         exp8 = model(req8, 8, 1'b0);
      end
   end

   // Per-cycle comparison against the model plus the one-hot invariant.
   always @(negedge clk) begin
      chk("model4", {4'd0, gnt4}, {4'd0, exp4});
      chk("model8", gnt8, exp8);
      chk("onehot4", {7'd0, $onehot0(gnt4)}, 8'd1);
      chk("onehot8", {7'd0, $onehot0(gnt8)}, 8'd1);
   end

   // Called at a falling edge: grant must hold until the next rising edge.
   task automatic apply(input logic [3:0] v, input logic [3:0] e,
                        input string name);
      req4 = v;
      #1;
      chk({name, "_hold"}, {4'd0, gnt4}, {4'd0, last_e});
      @(negedge clk);
      chk(name, {4'd0, gnt4}, {4'd0, e});
      last_e = e;
   endtask

   initial begin
      rst_n  = 1'b0;
      req4   = 4'b1111;
      req8   = 8'd0;
      last_e = 4'b0000;
      #1;
      chk("reset_async", {4'd0, gnt4}, 8'd0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", {4'd0, gnt4}, 8'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("release", {4'd0, gnt4}, 8'b0000_1000);
      last_e = 4'b1000;

      apply(4'b1000, 4'b1000, "single3");
      apply(4'b0010, 4'b0010, "single1");
      apply(4'b0100, 4'b0100, "single2");
      apply(4'b0001, 4'b0001, "single0");

      apply(4'b1010, 4'b1000, "cont_1010");
      apply(4'b0110, 4'b0100, "cont_0110");
      apply(4'b1110, 4'b1000, "cont_1110");
      apply(4'b1111, 4'b1000, "cont_1111");
      apply(4'b0011, 4'b0010, "cont_0011");

      apply(4'b0001, 4'b0001, "pre_0001");
      apply(4'b0101, 4'b0100, "pre_0101");
      apply(4'b0000, 4'b0000, "idle");

      apply(4'b0010, 4'b0010, "mid_setup");
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async", {4'd0, gnt4}, 8'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("mid_hold", {4'd0, gnt4}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_release", {4'd0, gnt4}, 8'b0000_0010);

      chk("pin8_a", model(8'b1010_0100, 8, 1'b0), 8'b0000_0100);
      chk("pin8_b", model(8'b1000_0000, 8, 1'b0), 8'b1000_0000);
      chk("pin4_a", model(8'b0000_0101, 4, 1'b1), 8'b0000_0100);

      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            req4 = 4'd0;
            req8 = 8'd0;
         end else begin
            req4 = 4'($urandom);
            req8 = 8'($urandom);
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
